retire_trace_tx: RTL and testbench

- Transmit side of the CPU/reference-model check interface.
- Captures one retirement record per instruction retired at the core's writeback stage and buffers it in a FIFO.
- Sends records to the bench scoreboard over a valid/ready channel. The scoreboard replays each record into the C model's decode/execute and checkreg/checkmemory path.
- Sits in the core top, tapping writeback. Synthesizable; has no effect on the architectural datapath except through stall_o.

---
 rtl/retire_trace_pkg.sv | 38 +++
 rtl/retire_trace_fifo.sv | 61 ++++++
 rtl/retire_trace_tx.sv | 140 ++++++++++++++
 tb/tb_retire_trace_tx.sv | 436 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/retire_trace_pkg.sv
// Shared types and default widths for the retirement trace transmitter and its consumers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package retire_trace_pkg;

   localparam int DEF_XLEN  = 16;
   localparam int DEF_ILEN  = 32;
   localparam int DEF_RA_W  = 3;
   localparam int DEF_SEQ_W = 16;
   localparam int DEF_DEPTH = 8;

   // Field order matches the bit order of tr_rec_o, seq in the MSBs.
   typedef struct packed {
      logic [DEF_SEQ_W-1:0] seq;
      logic [DEF_XLEN-1:0]  pc;
      logic [DEF_ILEN-1:0]  instr;
      logic                 rd_we;
      logic [DEF_RA_W-1:0]  rd;
      logic [DEF_XLEN-1:0]  rd_data;
      logic                 mem_we;
      logic [DEF_XLEN-1:0]  mem_addr;
      logic [DEF_XLEN-1:0]  mem_data;
   } retire_rec_t;

   localparam int REC_W = $bits(retire_rec_t);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } trace_state_e;

   // Record width for an arbitrary parameter set.
   function automatic int rec_width(input int xlen, input int ilen, input int ra_w, input int seq_w);
      return seq_w + 4 * xlen + ilen + ra_w + 2;
   endfunction

endpackage

// File: rtl/retire_trace_fifo.sv
// Generic first-word-fall-through FIFO; head entry reads as zero while empty.
// Latency: a push into an empty FIFO is visible on o_pop_dat the next cycle.
// Backpressure: o_push_rdy drops when full unless a pop happens in the same cycle.
module retire_trace_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   i_push_vld,
   input  logic [WIDTH-1:0]       i_push_dat,
   output logic                   o_push_rdy,
   input  logic                   i_pop_rdy,
   output logic                   o_pop_vld,
   output logic [WIDTH-1:0]       o_pop_dat,
   output logic [$clog2(DEPTH):0] o_level
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_level;
   logic             w_push;
   logic             w_pop;

   // Full/empty come from the occupancy count; pointers wrap naturally at DEPTH.
   assign o_pop_vld  = (r_level != '0);
   assign w_pop      = o_pop_vld && i_pop_rdy;
   assign o_push_rdy = (r_level != FULL_LVL) || w_pop;
   assign w_push     = i_push_vld && o_push_rdy;
   assign o_pop_dat  = o_pop_vld ? r_mem[r_rd_ptr] : '0;
   assign o_level    = r_level;

   // Storage array; contents are don't-care until written, masked by o_pop_vld.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= i_push_dat;
      end
   end

   // Pointer and occupancy bookkeeping; simultaneous push and pop leaves level unchanged.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_level  <= '0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (AW+1)'(1);
            2'b01:   r_level <= r_level - (AW+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

endmodule

// File: rtl/retire_trace_tx.sv
// Captures writeback retirements with a sequence number and streams them out of a FWFT FIFO.
// Latency: record on tr_rec_o one cycle after a push into an empty FIFO.
// Backpressure: stall_o at DEPTH-1 entries or while draining; full-FIFO pushes are dropped and counted.
// Optional: define RETIRE_TRACE_PARITY_EN to store and emit an even-parity bit per record.
module retire_trace_tx
   import retire_trace_pkg::*;
#(
   parameter int XLEN  = DEF_XLEN,
   parameter int ILEN  = DEF_ILEN,
   parameter int RA_W  = DEF_RA_W,
   parameter int DEPTH = DEF_DEPTH,
   parameter int SEQ_W = DEF_SEQ_W
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 ret_valid_i,
   input  logic [XLEN-1:0]                      ret_pc_i,
   input  logic [ILEN-1:0]                      ret_instr_i,
   input  logic                                 ret_rd_we_i,
   input  logic [RA_W-1:0]                      ret_rd_i,
   input  logic [XLEN-1:0]                      ret_rd_data_i,
   input  logic                                 ret_mem_we_i,
   input  logic [XLEN-1:0]                      ret_mem_addr_i,
   input  logic [XLEN-1:0]                      ret_mem_data_i,
   input  logic                                 flush_i,
   output logic                                 stall_o,
   output logic                                 tr_valid_o,
   input  logic                                 tr_ready_i,
   output logic [SEQ_W+4*XLEN+ILEN+RA_W+1:0]    tr_rec_o,
   output logic                                 tr_parity_o,
   output logic [$clog2(DEPTH):0]               level_o,
   output logic                                 overflow_o,
   output logic [7:0]                           drop_cnt_o,
   output logic                                 drain_done_o
);

   localparam int REC_W_L = rec_width(XLEN, ILEN, RA_W, SEQ_W);
   localparam int LVL_W   = $clog2(DEPTH) + 1;
   localparam logic [LVL_W-1:0] STALL_LVL = LVL_W'(DEPTH - 1);
`ifdef RETIRE_TRACE_PARITY_EN
   localparam int ENT_W = REC_W_L + 1;
`else
   localparam int ENT_W = REC_W_L;
`endif

   trace_state_e       r_state;
   trace_state_e       w_state_nxt;
   logic [SEQ_W-1:0]   r_seq;
   logic               r_overflow;
   logic [7:0]         r_drop_cnt;
   logic [REC_W_L-1:0] w_rec_in;
   logic [ENT_W-1:0]   w_ent_in;
   logic [ENT_W-1:0]   w_ent_out;
   logic               w_push_req;
   logic               w_push_rdy;
   logic               w_push_ok;
   logic               w_drop;
   logic [LVL_W-1:0]   w_level;

   // Record is stamped with the current sequence number at capture time.
   assign w_rec_in = {r_seq, ret_pc_i, ret_instr_i, ret_rd_we_i, ret_rd_i, ret_rd_data_i,
                      ret_mem_we_i, ret_mem_addr_i, ret_mem_data_i};

`ifdef RETIRE_TRACE_PARITY_EN
   assign w_ent_in    = {^w_rec_in, w_rec_in};
   assign tr_rec_o    = w_ent_out[REC_W_L-1:0];
   assign tr_parity_o = w_ent_out[REC_W_L];
`else
   assign w_ent_in    = w_rec_in;
   assign tr_rec_o    = w_ent_out;
   assign tr_parity_o = 1'b0;
`endif

   // Retirements are only captured while running; drain/done silently ignore them.
   assign w_push_req = ret_valid_i && (r_state == RUN);
   assign w_push_ok  = w_push_req && w_push_rdy;
   assign w_drop     = w_push_req && !w_push_rdy;
   assign level_o    = w_level;
   assign overflow_o = r_overflow;
   assign drop_cnt_o = r_drop_cnt;

   retire_trace_fifo #(
      .WIDTH (ENT_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_push_vld (w_push_req),
      .i_push_dat (w_ent_in),
      .o_push_rdy (w_push_rdy),
      .i_pop_rdy  (tr_ready_i),
      .o_pop_vld  (tr_valid_o),
      .o_pop_dat  (w_ent_out),
      .o_level    (w_level)
   );

   // Sequence advances only on accepted pushes; drops set the sticky flag and a saturating count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_seq      <= '0;
         r_overflow <= 1'b0;
         r_drop_cnt <= '0;
      end else begin
         if (w_push_ok) r_seq <= r_seq + SEQ_W'(1);
         if (w_drop) begin
            r_overflow <= 1'b1;
            if (r_drop_cnt != 8'hFF) r_drop_cnt <= r_drop_cnt + 8'd1;
         end
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= RUN;
      else        r_state <= w_state_nxt;
   end

   // Next state: flush starts a drain, empty FIFO completes it, flush release resumes.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         RUN:     if (flush_i)          w_state_nxt = DRAIN;
         DRAIN:   if (w_level == '0)    w_state_nxt = DONE;
         DONE:    if (!flush_i)         w_state_nxt = RUN;
         default:                       w_state_nxt = RUN;
      endcase
   end

   // Outputs: stall one entry early in RUN so a compliant core never overflows; drain_done marks the DRAIN->DONE cycle.
   always_comb begin
      stall_o      = 1'b1;
      drain_done_o = 1'b0;
      case (r_state)
         RUN:     stall_o      = (w_level >= STALL_LVL);
         DRAIN:   drain_done_o = (w_level == '0);
         default: stall_o      = 1'b1;
      endcase
   end

endmodule

// File: tb/tb_retire_trace_tx.sv
// Scoreboard bench for retire_trace_tx: expected records queued at push, compared at pop.
// Latency: checks first-record latency and drain timing.
// Backpressure: exercises stall, overflow drops, full push/pop and flush drain.
module tb_retire_trace_tx;
   import retire_trace_pkg::*;

   logic        clk;
   logic        rst_n;
   logic        ret_valid_i;
   logic [15:0] ret_pc_i;
   logic [31:0] ret_instr_i;
   logic        ret_rd_we_i;
   logic [2:0]  ret_rd_i;
   logic [15:0] ret_rd_data_i;
   logic        ret_mem_we_i;
   logic [15:0] ret_mem_addr_i;
   logic [15:0] ret_mem_data_i;
   logic        flush_i;
   logic        stall_o;
   logic        tr_valid_o;
   logic        tr_ready_i;
   logic [REC_W-1:0] tr_rec_o;
   logic        tr_parity_o;
   logic [3:0]  level_o;
   logic        overflow_o;
   logic [7:0]  drop_cnt_o;
   logic        drain_done_o;

   int tests = 0;
   int fails = 0;

   retire_rec_t  exp_q[$];
   int           m_level;
   int           m_lvl0;
   int           m_drops;
   logic [15:0]  m_seq;
   trace_state_e m_state;
   logic         m_pop;
   retire_rec_t  m_exp;
   retire_rec_t  m_got;

   retire_trace_tx dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ret_valid_i    (ret_valid_i),
      .ret_pc_i       (ret_pc_i),
      .ret_instr_i    (ret_instr_i),
      .ret_rd_we_i    (ret_rd_we_i),
      .ret_rd_i       (ret_rd_i),
      .ret_rd_data_i  (ret_rd_data_i),
      .ret_mem_we_i   (ret_mem_we_i),
      .ret_mem_addr_i (ret_mem_addr_i),
      .ret_mem_data_i (ret_mem_data_i),
      .flush_i        (flush_i),
      .stall_o        (stall_o),
      .tr_valid_o     (tr_valid_o),
      .tr_ready_i     (tr_ready_i),
      .tr_rec_o       (tr_rec_o),
      .tr_parity_o    (tr_parity_o),
      .level_o        (level_o),
      .overflow_o     (overflow_o),
      .drop_cnt_o     (drop_cnt_o),
      .drain_done_o   (drain_done_o)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference model and scoreboard, evaluated at the falling edge before each active edge.
   initial begin
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            exp_q.delete();
            m_level = 0;
            m_seq   = '0;
            m_drops = 0;
            m_state = RUN;
         end else begin
            m_lvl0 = m_level;
            tests++;
            if (level_o !== 4'(m_level)) begin
               fails++;
               $display("FAIL sb_level: got %0d expected %0d at %0t", level_o, m_level, $time);
            end
            tests++;
            if (tr_valid_o !== (m_level != 0)) begin
               fails++;
               $display("FAIL sb_valid: got %b expected %b at %0t", tr_valid_o, (m_level != 0), $time);
            end
            tests++;
            if (drop_cnt_o !== 8'(m_drops)) begin
               fails++;
               $display("FAIL sb_drop_cnt: got %0d expected %0d", drop_cnt_o, m_drops);
            end
            if (m_level == 0) begin
               tests++;
               if (tr_parity_o !== 1'b0) begin
                  fails++;
                  $display("FAIL sb_parity_empty: got %b expected 0", tr_parity_o);
               end
            end
            m_pop = (m_level != 0) && tr_ready_i;
            if (m_pop) begin
               if (exp_q.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL sb_pop_unexpected: record %h with empty scoreboard", tr_rec_o);
               end else begin
                  m_exp = exp_q.pop_front();
                  m_got = tr_rec_o;
                  tests++;
                  if (m_got !== m_exp) begin
                     fails++;
                     $display("FAIL sb_record: got %h expected %h", m_got, m_exp);
                  end
`ifdef RETIRE_TRACE_PARITY_EN
                  tests++;
                  if (tr_parity_o !== (^m_exp)) begin
                     fails++;
                     $display("FAIL sb_parity: got %b expected %b", tr_parity_o, ^m_exp);
                  end
`else
                  tests++;
                  if (tr_parity_o !== 1'b0) begin
                     fails++;
                     $display("FAIL sb_parity_tied: got %b expected 0", tr_parity_o);
                  end
`endif
               end
            end
            if (ret_valid_i && (m_state == RUN)) begin
               if ((m_level < 8) || m_pop) begin
                  m_exp.seq      = m_seq;
                  m_exp.pc       = ret_pc_i;
                  m_exp.instr    = ret_instr_i;
                  m_exp.rd_we    = ret_rd_we_i;
                  m_exp.rd       = ret_rd_i;
                  m_exp.rd_data  = ret_rd_data_i;
                  m_exp.mem_we   = ret_mem_we_i;
                  m_exp.mem_addr = ret_mem_addr_i;
                  m_exp.mem_data = ret_mem_data_i;
                  exp_q.push_back(m_exp);
                  m_seq   = m_seq + 16'd1;
                  m_level = m_level + 1;
               end else if (m_drops < 255) begin
                  m_drops = m_drops + 1;
               end
            end
            if (m_pop) m_level = m_level - 1;
            case (m_state)
               RUN:     if (flush_i)     m_state = DRAIN;
               DRAIN:   if (m_lvl0 == 0) m_state = DONE;
               DONE:    if (!flush_i)    m_state = RUN;
               default: m_state = RUN;
            endcase
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_ret(input int k);
      ret_valid_i    = 1'b1;
      ret_pc_i       = 16'(16'h0100 + k * 2);
      ret_instr_i    = $urandom;
      ret_rd_we_i    = k[0];
      ret_rd_i       = 3'(k);
      ret_rd_data_i  = 16'($urandom);
      ret_mem_we_i   = ~k[0];
      ret_mem_addr_i = 16'($urandom);
      ret_mem_data_i = 16'($urandom);
   endtask

   task automatic wait_empty();
      int n = 0;
      while (level_o != 4'd0 && n < 40) begin
         step();
         n++;
      end
      tests++;
      if (level_o !== 4'd0) begin
         fails++;
         $display("FAIL wait_empty_timeout: level %0d expected 0", level_o);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      tests++;
      if ({level_o, tr_valid_o, tr_rec_o, overflow_o, drop_cnt_o, stall_o, drain_done_o, tr_parity_o}
          !== '0) begin
         fails++;
         $display("FAIL %s: level=%0d valid=%b rec=%h ovf=%b drop=%0d stall=%b done=%b par=%b expected all 0",
                  tag, level_o, tr_valid_o, tr_rec_o, overflow_o, drop_cnt_o, stall_o, drain_done_o, tr_parity_o);
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      ret_valid_i = 1'b0; ret_pc_i = '0; ret_instr_i = '0; ret_rd_we_i = 1'b0; ret_rd_i = '0;
      ret_rd_data_i = '0; ret_mem_we_i = 1'b0; ret_mem_addr_i = '0; ret_mem_data_i = '0;
      flush_i = 1'b0; tr_ready_i = 1'b0;
      #2;
      check_reset_outputs("reset_values");
      step();
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_single();
      retire_rec_t r;
      ret_valid_i = 1'b1; ret_pc_i = 16'h0010; ret_instr_i = 32'h12345678; ret_rd_we_i = 1'b1;
      ret_rd_i = 3'd3; ret_rd_data_i = 16'h00AA; ret_mem_we_i = 1'b0; ret_mem_addr_i = '0; ret_mem_data_i = '0;
      tr_ready_i = 1'b1;
      step();
      ret_valid_i = 1'b0;
      r = tr_rec_o;
      tests++;
      if (tr_valid_o !== 1'b1) begin
         fails++;
         $display("FAIL single_latency: valid %b expected 1", tr_valid_o);
      end
      tests++;
      if ({r.seq, r.pc, r.instr, r.rd, r.rd_data} !== {16'd0, 16'h0010, 32'h12345678, 3'd3, 16'h00AA}) begin
         fails++;
         $display("FAIL single_fields: seq=%h pc=%h instr=%h rd=%0d data=%h", r.seq, r.pc, r.instr, r.rd, r.rd_data);
      end
      step();
      tests++;
      if (level_o !== 4'd0) begin
         fails++;
         $display("FAIL single_level: got %0d expected 0", level_o);
      end
   endtask

   task automatic test_burst();
      tr_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_ret(i);
         step();
         tests++;
         if (stall_o !== (i >= 6)) begin
            fails++;
            $display("FAIL burst_stall: level %0d stall %b expected %b", i + 1, stall_o, (i >= 6));
         end
      end
      ret_valid_i = 1'b0;
      tests++;
      if (level_o !== 4'd8) begin
         fails++;
         $display("FAIL burst_level: got %0d expected 8", level_o);
      end
      tr_ready_i = 1'b1;
      wait_empty();
      tests++;
      if ({overflow_o, drop_cnt_o} !== 9'd0) begin
         fails++;
         $display("FAIL burst_no_drop: ovf=%b drop=%0d expected 0/0", overflow_o, drop_cnt_o);
      end
   endtask

   task automatic test_overflow();
      logic [15:0] base;
      retire_rec_t r;
      base = m_seq;
      tr_ready_i = 1'b0;
      for (int i = 0; i < 10; i++) begin
         set_ret(i + 20);
         step();
      end
      ret_valid_i = 1'b0;
      tests++;
      if ({overflow_o, drop_cnt_o, level_o} !== {1'b1, 8'd2, 4'd8}) begin
         fails++;
         $display("FAIL overflow_flags: ovf=%b drop=%0d level=%0d expected 1/2/8", overflow_o, drop_cnt_o, level_o);
      end
      tr_ready_i = 1'b1;
      wait_empty();
      tr_ready_i = 1'b0;
      set_ret(40);
      step();
      ret_valid_i = 1'b0;
      r = tr_rec_o;
      tests++;
      if (r.seq !== base + 16'd8) begin
         fails++;
         $display("FAIL overflow_next_seq: got %0d expected %0d", r.seq, base + 16'd8);
      end
      tr_ready_i = 1'b1;
      wait_empty();
   endtask

   task automatic test_full_pushpop();
      tr_ready_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         set_ret(i + 50);
         step();
      end
      set_ret(60);
      tr_ready_i = 1'b1;
      step();
      ret_valid_i = 1'b0;
      tr_ready_i = 1'b0;
      tests++;
      if ({level_o, drop_cnt_o} !== {4'd8, 8'd2}) begin
         fails++;
         $display("FAIL full_pushpop: level=%0d drop=%0d expected 8/2", level_o, drop_cnt_o);
      end
      tr_ready_i = 1'b1;
      wait_empty();
   endtask

   task automatic test_drain();
      int pops = 0;
      int pulses = 0;
      logic [15:0] base;
      retire_rec_t r;
      base = m_seq;
      tr_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         set_ret(i + 70);
         step();
      end
      ret_valid_i = 1'b0;
      flush_i = 1'b1;
      tr_ready_i = 1'b1;
      for (int c = 0; c < 12; c++) begin
         if (tr_valid_o && tr_ready_i) pops++;
         if (drain_done_o) begin
            pulses++;
            tests++;
            if (pops !== 3) begin
               fails++;
               $display("FAIL drain_pulse_early: pops %0d at pulse expected 3", pops);
            end
         end
         if (c > 0) set_ret(c + 80);
         ret_valid_i = (c > 0) ? c[0] : 1'b0;
         step();
      end
      ret_valid_i = 1'b0;
      tests++;
      if (pops !== 3 || pulses !== 1) begin
         fails++;
         $display("FAIL drain_counts: pops=%0d pulses=%0d expected 3/1", pops, pulses);
      end
      tests++;
      if ({drop_cnt_o, stall_o, level_o} !== {8'd2, 1'b1, 4'd0}) begin
         fails++;
         $display("FAIL drain_done_state: drop=%0d stall=%b level=%0d expected 2/1/0", drop_cnt_o, stall_o, level_o);
      end
      flush_i = 1'b0;
      step();
      tests++;
      if (stall_o !== 1'b0) begin
         fails++;
         $display("FAIL drain_resume_stall: got %b expected 0", stall_o);
      end
      tr_ready_i = 1'b0;
      set_ret(99);
      step();
      ret_valid_i = 1'b0;
      r = tr_rec_o;
      tests++;
      if (r.seq !== base + 16'd3) begin
         fails++;
         $display("FAIL drain_seq_continue: got %0d expected %0d", r.seq, base + 16'd3);
      end
      tr_ready_i = 1'b1;
      wait_empty();
   endtask

   task automatic test_reset_mid();
      retire_rec_t r;
      tr_ready_i = 1'b0;
      for (int i = 0; i < 5; i++) begin
         set_ret(i + 110);
         step();
      end
      ret_valid_i = 1'b0;
      tests++;
      if (level_o !== 4'd5) begin
         fails++;
         $display("FAIL reset_mid_level: got %0d expected 5", level_o);
      end
      #2;
      rst_n = 1'b0;
      #1;
      check_reset_outputs("reset_mid_async");
      step();
      rst_n = 1'b1;
      step();
      set_ret(120);
      step();
      ret_valid_i = 1'b0;
      r = tr_rec_o;
      tests++;
      if (r.seq !== 16'd0) begin
         fails++;
         $display("FAIL reset_mid_seq: got %0d expected 0", r.seq);
      end
      tr_ready_i = 1'b1;
      wait_empty();
      step();
      tests++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL scoreboard_leftover: %0d records never popped, expected 0", exp_q.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_burst();
      test_overflow();
      test_full_pushpop();
      test_drain();
      test_reset_mid();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
